// File: rtl/para_bitscan_encoder_pkg.sv
// Shared encoder types and a reusable lowest-set-bit helper.
// Pure declarations: no latency, no flow control.
package para_enc_pkg;

  typedef enum logic {IDLE, SCAN} bitscan_state_t;

  // Widest vector the helper handles; narrower vectors are zero-extended.
  localparam int ffs_max_width = 256;

  function automatic int lowest_set_idx(input logic [ffs_max_width-1:0] vec);
    int idx;
    idx = 0;
    for (int i = ffs_max_width - 1; i >= 0; i--) begin
      if (vec[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/para_bitscan_encoder_ffs_encoder.sv
// Find-first-set: index of the lowest set bit of vec, any_set when vec != 0.
// Purely combinational, zero latency, no backpressure.
module ffs_encoder
  import para_enc_pkg::*;
#(
  parameter int in_width  = 4,
  parameter int out_width = 2
) (
  input  logic [in_width-1:0]  vec,
  output logic [out_width-1:0] idx,
  output logic                 any_set
);

  logic [ffs_max_width-1:0] vec_ext;

  always_comb begin
    vec_ext                = '0;
    vec_ext[in_width-1:0]  = vec;
    idx                    = out_width'(lowest_set_idx(vec_ext));
    any_set                = |vec;
  end

endmodule

// File: rtl/para_bitscan_encoder.sv
// Serialises a multi-hot request into binary indices, lowest first; first index the cycle after accept.
// Accepts only in IDLE; idx_ready low stalls the scan with idx_out/idx_last/pending held.
module para_bitscan_encoder
  import para_enc_pkg::*;
#(
  parameter int in_width  = 4,
  parameter int out_width = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [in_width-1:0]  req_in,
  input  logic                 req_valid,
  output logic                 req_ready,
  output logic [out_width-1:0] idx_out,
  output logic                 idx_valid,
  input  logic                 idx_ready,
  output logic                 idx_last,
  output logic                 busy
);

  if (in_width > (1 << out_width)) begin : g_bad_out_width
    $error("para_bitscan_encoder: in_width exceeds 2**out_width");
  end
  if (in_width > ffs_max_width) begin : g_bad_in_width
    $error("para_bitscan_encoder: in_width exceeds ffs helper range");
  end

  bitscan_state_t          state;
  logic [in_width-1:0]     pending;
  logic [in_width-1:0]     pending_next;
  logic [out_width-1:0]    ffs_idx;
  logic                    any_set;

  ffs_encoder #(
    .in_width  (in_width),
    .out_width (out_width)
  ) u_ffs (
    .vec     (pending),
    .idx     (ffs_idx),
    .any_set (any_set)
  );

  // Clearing the lowest set bit: x & (x-1).
  assign pending_next = pending & (pending - in_width'(1));

  assign busy      = (state == SCAN);
  assign req_ready = (state == IDLE);
  assign idx_valid = busy && any_set;
  assign idx_out   = idx_valid ? ffs_idx : '0;
  assign idx_last  = idx_valid && (pending_next == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      pending <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_in != '0) begin
            pending <= req_in;
            state   <= SCAN;
          end
        end
        SCAN: begin
          if (idx_valid && idx_ready) begin
            pending <= pending_next;
            if (pending_next == '0) state <= IDLE;
          end
        end
        default: begin
          state   <= IDLE;
          pending <= '0;
        end
      endcase
    end
  end

  a_valid_pending: assert property (@(posedge clk) disable iff (rst)
    idx_valid |-> (pending != '0));

  a_hold_stall: assert property (@(posedge clk) disable iff (rst)
    (idx_valid && !idx_ready) |=> ($stable(idx_out) && $stable(pending)));

  a_ready_busy: assert property (@(posedge clk)
    req_ready == !busy);

endmodule

// File: tb/tb_para_bitscan_encoder.sv
// Directed bench for para_bitscan_encoder at 4/2 and 8/3; stimulus pushes expected
// {last, idx} beats into queues, per-instance monitors pop and compare on each handshake.
module tb_para_bitscan_encoder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // 4-bit instance
  logic [3:0] a_req_in;
  logic       a_req_valid, a_req_ready, a_idx_valid, a_idx_ready, a_idx_last, a_busy;
  logic [1:0] a_idx_out;

  // 8-bit instance
  logic [7:0] b_req_in;
  logic       b_req_valid, b_req_ready, b_idx_valid, b_idx_ready, b_idx_last, b_busy;
  logic [2:0] b_idx_out;

  para_bitscan_encoder #(.in_width(4), .out_width(2)) dut_a (
    .clk       (clk),
    .rst       (rst),
    .req_in    (a_req_in),
    .req_valid (a_req_valid),
    .req_ready (a_req_ready),
    .idx_out   (a_idx_out),
    .idx_valid (a_idx_valid),
    .idx_ready (a_idx_ready),
    .idx_last  (a_idx_last),
    .busy      (a_busy)
  );

  para_bitscan_encoder #(.in_width(8), .out_width(3)) dut_b (
    .clk       (clk),
    .rst       (rst),
    .req_in    (b_req_in),
    .req_valid (b_req_valid),
    .req_ready (b_req_ready),
    .idx_out   (b_idx_out),
    .idx_valid (b_idx_valid),
    .idx_ready (b_idx_ready),
    .idx_last  (b_idx_last),
    .busy      (b_busy)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {int idx; int last;} beat_t;
  beat_t exp_a[$];
  beat_t exp_b[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_a(input int idx, input int last);
    beat_t b;
    b.idx = idx; b.last = last;
    exp_a.push_back(b);
  endtask

  task automatic push_b(input int idx, input int last);
    beat_t b;
    b.idx = idx; b.last = last;
    exp_b.push_back(b);
  endtask

  // Monitors: a handshake under rst is overridden, so it is not a transfer.
  always @(negedge clk) begin
    if (!rst && a_idx_valid && a_idx_ready) begin
      if (exp_a.size() == 0) begin
        chk("a_unexpected_beat_idx", int'(a_idx_out), -1);
      end else begin
        beat_t e;
        e = exp_a.pop_front();
        chk("a_idx_out", int'(a_idx_out), e.idx);
        chk("a_idx_last", int'(a_idx_last), e.last);
      end
    end
    if (!rst && b_idx_valid && b_idx_ready) begin
      if (exp_b.size() == 0) begin
        chk("b_unexpected_beat_idx", int'(b_idx_out), -1);
      end else begin
        beat_t e;
        e = exp_b.pop_front();
        chk("b_idx_out", int'(b_idx_out), e.idx);
        chk("b_idx_last", int'(b_idx_last), e.last);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    a_req_in = '0; a_req_valid = 1'b0; a_idx_ready = 1'b1;
    b_req_in = '0; b_req_valid = 1'b0; b_idx_ready = 1'b1;
    tick();
    tick();

    // Reset state
    chk("rst_idx_valid", int'(a_idx_valid), 0);
    chk("rst_idx_out",   int'(a_idx_out),   0);
    chk("rst_idx_last",  int'(a_idx_last),  0);
    chk("rst_busy",      int'(a_busy),      0);
    chk("rst_req_ready", int'(a_req_ready), 1);
    rst = 1'b0;
    tick();

    // 1011 -> 0,1,3 back to back
    push_a(0, 0); push_a(1, 0); push_a(3, 1);
    a_req_in = 4'b1011; a_req_valid = 1'b1;
    tick();
    a_req_valid = 1'b0;
    chk("t1_first_valid", int'(a_idx_valid), 1);
    chk("t1_req_ready_scan", int'(a_req_ready), 0);
    tick(); tick(); tick();
    chk("t1_req_ready_after", int'(a_req_ready), 1);
    chk("t1_beats_left", exp_a.size(), 0);

    // 1000 -> single beat 3 with last
    push_a(3, 1);
    a_req_in = 4'b1000; a_req_valid = 1'b1;
    tick();
    a_req_valid = 1'b0;
    chk("t2_idx_last", int'(a_idx_last), 1);
    tick();
    chk("t2_idle_valid", int'(a_idx_valid), 0);
    chk("t2_idle_ready", int'(a_req_ready), 1);

    // 0110 with 3 stall cycles; a request offered during SCAN is ignored
    push_a(1, 0); push_a(2, 1);
    a_idx_ready = 1'b0;
    a_req_in = 4'b0110; a_req_valid = 1'b1;
    tick();
    a_req_in = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      chk("t3_stall_valid", int'(a_idx_valid), 1);
      chk("t3_stall_idx",   int'(a_idx_out),   1);
      chk("t3_stall_last",  int'(a_idx_last),  0);
      chk("t3_stall_ready", int'(a_req_ready), 0);
      tick();
    end
    a_req_valid = 1'b0;
    a_idx_ready = 1'b1;
    tick(); tick();
    chk("t3_idle_ready", int'(a_req_ready), 1);
    chk("t3_beats_left", exp_a.size(), 0);

    // All-zero vector is accepted and dropped
    a_req_in = 4'b0000; a_req_valid = 1'b1;
    tick();
    a_req_valid = 1'b0;
    chk("t4_valid", int'(a_idx_valid), 0);
    chk("t4_busy",  int'(a_busy),      0);
    chk("t4_ready", int'(a_req_ready), 1);
    tick();
    chk("t4_valid_later", int'(a_idx_valid), 0);

    // 1111, reset after the second handshake
    push_a(0, 0); push_a(1, 0);
    a_req_in = 4'b1111; a_req_valid = 1'b1;
    tick();
    a_req_valid = 1'b0;
    tick(); tick();
    chk("t5_pre_rst_idx", int'(a_idx_out), 2);
    rst = 1'b1;
    tick();
    chk("t5_rst_valid", int'(a_idx_valid), 0);
    chk("t5_rst_busy",  int'(a_busy),      0);
    chk("t5_rst_ready", int'(a_req_ready), 1);
    rst = 1'b0;
    chk("t5_beats_left", exp_a.size(), 0);
    push_a(2, 1);
    a_req_in = 4'b0100; a_req_valid = 1'b1;
    tick();
    a_req_valid = 1'b0;
    chk("t5_new_idx",  int'(a_idx_out),  2);
    chk("t5_new_last", int'(a_idx_last), 1);
    tick();
    chk("t5_idle_ready", int'(a_req_ready), 1);

    // 8-bit instance, all ones -> 0..7
    for (int i = 0; i < 8; i++) push_b(i, (i == 7) ? 1 : 0);
    b_req_in = 8'hFF; b_req_valid = 1'b1;
    tick();
    b_req_valid = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    chk("t6_req_ready", int'(b_req_ready), 1);
    chk("t6_beats_left", exp_b.size(), 0);

    tick(); tick();
    chk("final_a_left", exp_a.size(), 0);
    chk("final_b_left", exp_b.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/para_bitscan_encoder.md
Name: para_bitscan_encoder

Overview:
Sequential counterpart to the team's parameterized one-hot decoder. It accepts a multi-hot request vector and serially emits the binary index of every set bit, lowest index first, over a valid/ready stream. It sits where a bit-vector of pending events must be converted back into binary indices, one per cycle, for a downstream consumer.

Parameters:
in_width, 4, width of the request vector (number of bit positions).
out_width, 2, width of the emitted index; must satisfy in_width <= 2**out_width (elaboration-time assertion).

Ports:
clk  input  1  single clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
req_in  input  in_width  request vector; sampled only on an accept
req_valid  input  1  req_in is valid
req_ready  output  1  block can accept a new vector (high only in IDLE)
idx_out  output  out_width  binary index of the lowest remaining set bit
idx_valid  output  1  idx_out is valid
idx_ready  input  1  consumer accepts idx_out this cycle
idx_last  output  1  idx_out is the final index of the current vector
busy  output  1  high while in SCAN

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high, rst.
- Reset, evaluated at the clk edge with rst=1:
  - state=IDLE, pending=0.
  - Outputs: idx_valid=0, idx_out=0, idx_last=0, busy=0, req_ready=1.
  - rst overrides every other input in that cycle.
- State: 2-state FSM plus pending register (in_width bits).
- IDLE:
  - req_ready=1, idx_valid=0, idx_out=0, idx_last=0.
  - On req_valid&&req_ready with req_in!=0: pending<=req_in, next state SCAN.
  - On req_valid&&req_ready with req_in==0: vector is accepted and dropped, no index is emitted, state stays IDLE.
- SCAN:
  - req_ready=0, busy=1, idx_valid=1.
  - idx_out = position of the lowest set bit of pending. It is combinational from the registered pending only, with no path from req_in.
  - idx_last = 1 when pending has exactly one bit set.
  - On idx_valid&&idx_ready: clear that bit in pending. If the result is 0 (i.e. idx_last was 1), next state is IDLE.
  - While idx_ready=0: idx_out, idx_last and pending hold stable.
- Timing:
  - First index is valid the cycle after acceptance.
  - Throughput is 1 index/cycle while idx_ready=1.
  - A vector with N set bits occupies SCAN for at least N cycles.
  - One IDLE cycle is required between vectors; there is no same-cycle reload on the last handshake.
- Boundary conditions:
  - req_in is ignored whenever req_ready=0.
  - req_in bits are only meaningful below in_width. When in_width < 2**out_width, idx_out never exceeds in_width-1.
  - An all-ones vector emits indices 0..in_width-1 in order.
  - rst during SCAN discards pending; idx_valid=0 from the following cycle.
- Assertions:
  - idx_valid implies pending!=0.
  - Stability of idx_out under backpressure.
  - req_ready equals !busy.

Decomposition:
- Shared package para_enc_pkg holds:
  - typedef enum logic {IDLE, SCAN} bitscan_state_t.
  - Helper function for lowest-set-bit index, reusable by other encoders.
- Sub-module ffs_encoder: purely combinational find-first-set. Parameters in_width/out_width; inputs vec; outputs idx and any_set.
- The top level holds the FSM, the pending register and the handshake.

Test Plan:
- in_width=4, req_in=4'b1011, idx_ready=1 -> idx_out 0,1,3 on three consecutive cycles; idx_last=1 only with 3; req_ready=1 on the following cycle.
- req_in=4'b1000 -> single beat idx_out=3 with idx_last=1; back to IDLE next cycle.
- req_in=4'b0110, idx_ready held 0 for 3 cycles -> idx_out=1 stable with idx_valid=1; then idx_ready=1 -> 1,2 emitted; a new req_valid during SCAN is not accepted.
- req_in=4'b0000 with req_valid=1 -> idx_valid stays 0, busy stays 0, req_ready stays 1.
- req_in=4'b1111, rst=1 after the second index handshake -> idx_valid=0 from the next cycle; pending=0; a subsequent req_in=4'b0100 yields idx_out=2, idx_last=1.
- in_width=8, out_width=3, req_in=8'hFF, idx_ready=1 -> indices 0..7 on 8 consecutive cycles; idx_last only on 7.
